// File: rtl/codec_frame_serializer.sv
// I2S frame generator: derives BCLK/LRCLK from clk, serializes the mono DAC sample
// onto both slots and deserializes the codec ADC stream into left/right words.
module codec_frame_serializer #(
  parameter int unsigned BCLK_DIV     = 2,
  parameter int unsigned SLOT_BITS    = 32,
  parameter int unsigned SAMPLE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sdin,
  output logic                    new_frame,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    sdout,
  output logic [SAMPLE_WIDTH-1:0] adc_left,
  output logic [SAMPLE_WIDTH-1:0] adc_right,
  output logic                    adc_valid
);

  localparam int unsigned DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int unsigned POS_W      = $clog2(2 * SLOT_BITS);
  localparam int unsigned FRAME_LAST = 2 * SLOT_BITS - 1;

  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [POS_W-1:0]        pos_q, pos_d;
  logic                    bclk_q, bclk_d;
  logic                    lrclk_q, lrclk_d;
  logic                    sdout_q, sdout_d;
  logic                    new_frame_q, new_frame_d;
  logic                    adc_valid_q, adc_valid_d;
  logic [SAMPLE_WIDTH-1:0] tx_word_q, tx_word_d;
  logic [SAMPLE_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [SAMPLE_WIDTH-1:0] rx_left_q, rx_left_d;
  logic [SAMPLE_WIDTH-1:0] adc_left_q, adc_left_d;
  logic [SAMPLE_WIDTH-1:0] adc_right_q, adc_right_d;

  logic                    div_term, rise_evt, fall_evt;
  logic [POS_W-1:0]        pos_inc, slot_cur, slot_nxt;
  logic [SAMPLE_WIDTH-1:0] rx_word;
  logic                    tx_bit;

  function automatic logic [POS_W-1:0] slot_of(input logic [POS_W-1:0] p);
    return (p >= POS_W'(SLOT_BITS)) ? p - POS_W'(SLOT_BITS) : p;
  endfunction

  // Event decode and position bookkeeping shared by the TX and RX paths
  always_comb begin
    div_term = (div_cnt_q == DIV_W'(BCLK_DIV - 1));
    rise_evt = div_term && !bclk_q;
    fall_evt = div_term && bclk_q;
    pos_inc  = (pos_q == POS_W'(FRAME_LAST)) ? '0 : pos_q + POS_W'(1);
    slot_cur = slot_of(pos_q);
    slot_nxt = slot_of(pos_inc);
    rx_word  = {rx_shift_q[SAMPLE_WIDTH-2:0], sdin};
    tx_bit   = 1'b0;
    for (int unsigned i = 0; i < SAMPLE_WIDTH; i++) begin
      if (slot_nxt == POS_W'(SAMPLE_WIDTH - i)) tx_bit = tx_word_q[i];
    end
  end

  always_comb begin
    div_cnt_d   = div_term ? '0 : div_cnt_q + DIV_W'(1);
    bclk_d      = bclk_q ^ div_term;
    pos_d       = pos_q;
    lrclk_d     = lrclk_q;
    sdout_d     = sdout_q;
    new_frame_d = 1'b0;
    adc_valid_d = 1'b0;
    tx_word_d   = tx_word_q;
    rx_shift_d  = rx_shift_q;
    rx_left_d   = rx_left_q;
    adc_left_d  = adc_left_q;
    adc_right_d = adc_right_q;

    // Falling BCLK: advance position, launch next DAC bit (MSB lags LRCLK by one bit)
    if (fall_evt) begin
      pos_d   = pos_inc;
      lrclk_d = (pos_inc >= POS_W'(SLOT_BITS));
      sdout_d = tx_bit;
      if (pos_inc == '0) begin
        new_frame_d = 1'b1;
        tx_word_d   = sample_in;
      end
    end

    // Rising BCLK: shift in ADC bits for the active word positions of the slot
    if (rise_evt && (slot_cur >= POS_W'(1)) && (slot_cur <= POS_W'(SAMPLE_WIDTH))) begin
      rx_shift_d = rx_word;
      if (slot_cur == POS_W'(SAMPLE_WIDTH)) begin
        if (pos_q < POS_W'(SLOT_BITS)) begin
          rx_left_d = rx_word;
        end else begin
          adc_left_d  = rx_left_q;
          adc_right_d = rx_word;
          adc_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q   <= '0;
      pos_q       <= '0;
      bclk_q      <= 1'b0;
      lrclk_q     <= 1'b0;
      sdout_q     <= 1'b0;
      new_frame_q <= 1'b0;
      adc_valid_q <= 1'b0;
      tx_word_q   <= '0;
      rx_shift_q  <= '0;
      rx_left_q   <= '0;
      adc_left_q  <= '0;
      adc_right_q <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      pos_q       <= pos_d;
      bclk_q      <= bclk_d;
      lrclk_q     <= lrclk_d;
      sdout_q     <= sdout_d;
      new_frame_q <= new_frame_d;
      adc_valid_q <= adc_valid_d;
      tx_word_q   <= tx_word_d;
      rx_shift_q  <= rx_shift_d;
      rx_left_q   <= rx_left_d;
      adc_left_q  <= adc_left_d;
      adc_right_q <= adc_right_d;
    end
  end

  assign new_frame = new_frame_q;
  assign bclk      = bclk_q;
  assign lrclk     = lrclk_q;
  assign sdout     = sdout_q;
  assign adc_left  = adc_left_q;
  assign adc_right = adc_right_q;
  assign adc_valid = adc_valid_q;

endmodule

// File: doc/codec_frame_serializer.md
# codec_frame_serializer

Codec-side end of the sample/frame handshake used by the music player. It generates the serial audio clocks (BCLK, LRCLK) and the once-per-frame `new_frame` pulse that paces sample production. It serializes the player's 16-bit mono sample MSB-first, in I2S format, onto both DAC channels. It also deserializes the codec's ADC stream into parallel left/right words.

## Interface
- `BCLK_DIV`, default 2: clk cycles per BCLK half-period; legal range ≥1.
- `SLOT_BITS`, default 32: BCLK periods per channel slot; must be ≥ `SAMPLE_WIDTH`+1.
- `SAMPLE_WIDTH`, default 16: audio word width.

Ports:
- `clk` input 1: system clock; the only clock.
- `reset` input 1: asynchronous, active-low reset.
- `sample_in` input `SAMPLE_WIDTH`: mono DAC sample from the player.
- `sdin` input 1: serial ADC data from the codec.
- `new_frame` output 1: one-clk pulse at each frame start.
- `bclk` output 1: serial bit clock.
- `lrclk` output 1: word select; 0 = left slot, 1 = right slot.
- `sdout` output 1: serial DAC data.
- `adc_left` output `SAMPLE_WIDTH`: last captured left ADC word.
- `adc_right` output `SAMPLE_WIDTH`: last captured right ADC word.
- `adc_valid` output 1: one-clk pulse when `adc_left`/`adc_right` update.

## Operation
- **Divider.** `div_cnt` counts 0..`BCLK_DIV`-1 and wraps. At the terminal count, `bclk` toggles.
  - A 0→1 toggle is a *rise event*.
  - A 1→0 toggle is a *fall event*.
- **Position counter.** `pos` counts 0..2·`SLOT_BITS`-1 and increments on each fall event, wrapping to 0. Define `slot_pos = pos mod SLOT_BITS`.
- **Word select.** `lrclk` is registered as `pos ≥ SLOT_BITS`, evaluated with the post-increment value.
- **Frame start.** This is the fall event on which `pos` wraps to 0. On that clk cycle:
  - `new_frame` = 1.
  - `sample_in` is captured into holding register `tx_word`.
  - One frame of latency is inherent: the player answers `new_frame` with a sample that is transmitted in the next frame.
- **DAC data.**
  - On each fall event, `sdout` = `tx_word[SAMPLE_WIDTH - slot_pos]` for `slot_pos` 1..`SAMPLE_WIDTH`; otherwise 0.
  - I2S one-BCLK delay: the MSB follows the `lrclk` edge by one BCLK.
  - The same `tx_word` is sent in both slots.
- **ADC data.**
  - On each rise event with `slot_pos` in 1..`SAMPLE_WIDTH`, `sdin` shifts into `rx_shift` LSB-first-in, so the first bit captured ends up as the MSB.
  - On the rise event at `slot_pos` = `SAMPLE_WIDTH`:
    - left slot: store the word into `rx_left`;
    - right slot: drive `adc_left` ← `rx_left` and `adc_right` ← completed word, and pulse `adc_valid` for one clk.
- **Arithmetic.** All data is passed through unmodified; no sign extension, no scaling.

## Timing
- **Reset values.**
  - Outputs: `bclk` = 0, `lrclk` = 0, `sdout` = 0, `new_frame` = 0, `adc_valid` = 0, `adc_left` = `adc_right` = 0.
  - Internal: `div_cnt` = `pos` = 0, `tx_word` = 0, `rx_shift` = `rx_left` = 0.
  - `new_frame` does not pulse on reset release.
- **Register timing.**
  - All outputs are registered from the same clk edge, so `sdout` and `lrclk` change on the same edge on which `bclk` falls.
  - The codec samples on the rise, `BCLK_DIV` clks later.
- **Periods.**
  - Fall events occur every 2·`BCLK_DIV` clks.
  - Frame period is 4·`BCLK_DIV`·`SLOT_BITS` clks.
  - The first fall event occurs 2·`BCLK_DIV` clks after reset deassertion.
  - The first `new_frame` occurs 4·`BCLK_DIV`·`SLOT_BITS` clks after reset deassertion.
- **Sample capture.**
  - `sample_in` is sampled only on the `new_frame` cycle. Changes at any other time have no effect on the frame in flight.
  - No ready/valid handshake exists: upstream must hold a stable sample before the next `new_frame`.
- **`BCLK_DIV` = 1.** `bclk` toggles every clk and all the rules above still apply.
- **Reset mid-frame.**
  - Asynchronous assertion immediately forces all reset values, including `bclk` = 0.
  - No partial `adc_valid` pulse is emitted.
  - The framing restarts from `pos` = 0.
- **Unused slot positions.** `slot_pos` 0 and `slot_pos` > `SAMPLE_WIDTH`: `sdout` = 0 and `sdin` is ignored.

## Test plan
- **Reset and clocks.** Defaults (div 2, slot 32). Release reset → `bclk` period = 4 clk; `lrclk` low 128 clk then high 128 clk; `new_frame` first at clk 256 after release, then every 256 clk, each exactly 1 clk wide.
- **DAC serialization.** Hold `sample_in` = 16'hA5C3 across `new_frame`. In the next frame, `sdout` at left `slot_pos` 1..16 = 1010_0101_1100_0011, the same in the right slot, and 0 elsewhere. The frame before it transmits all zeros.
- **Late update ignored.** Change `sample_in` to 16'h1234 one clk after `new_frame` → the current frame still sends the value captured at `new_frame`.
- **ADC capture.** Drive `sdin` aligned to rise events with left word 16'h8001 and right word 16'h7FFE → a single `adc_valid` pulse at the right-slot position-16 rise, with `adc_left` = 16'h8001 and `adc_right` = 16'h7FFE.
- **Reset mid-frame.** Assert `reset` low at `pos` = 40 → outputs go to their reset values asynchronously and no `adc_valid` pulses. After release, timing matches the reset test.
- **`BCLK_DIV` = 1.** `bclk` period = 2 clk; frame period = 128 clk; serialization is bit-exact per the DAC serialization test.
